// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: load-use and flag stalls,
// taken-branch flushes, EX operand forwarding selects and saturating event counters.
module pipe_hazard_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_Rn,
   input  logic [4:0]       id_Rm,
   input  logic             id_use_Rn,
   input  logic             id_use_Rm,
   input  logic             id_is_bcond,
   input  logic [4:0]       ex_destreg,
   input  logic [4:0]       ex_Rn,
   input  logic [4:0]       ex_Rm,
   input  logic             ex_RegWrite,
   input  logic             ex_MemRead,
   input  logic             ex_SetFlags,
   input  logic [4:0]       mem_destreg,
   input  logic             mem_RegWrite,
   input  logic             mem_br_taken,
   input  logic [4:0]       wb_destreg,
   input  logic             wb_RegWrite,
   output logic             pc_hold,
   output logic             ifde_hold,
   output logic             idex_bubble,
   output logic             flush_ifde,
   output logic             flush_idex,
   output logic             flush_exmem,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [4:0] XZR = 5'd31;

   typedef enum logic [1:0] {RUN, STALL, SHADOW} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             lu, fh, stall_req, flush;

   // EX/MEM takes priority over MEM/WB; XZR is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic mem_we, input logic [4:0] mem_rd,
                                          input logic wb_we, input logic [4:0] wb_rd);
      logic [1:0] sel;
      sel = 2'b00;
      if (rs != XZR) begin
         if (mem_we && (mem_rd == rs))
            sel = 2'b10;
         else if (wb_we && (wb_rd == rs))
            sel = 2'b01;
      end
      return sel;
   endfunction

   always_comb begin
      lu = ex_MemRead && ex_RegWrite && (ex_destreg != XZR) &&
           ((id_use_Rn && (id_Rn == ex_destreg)) || (id_use_Rm && (id_Rm == ex_destreg)));
      fh = id_is_bcond && ex_SetFlags;
      stall_req = (lu || fh) && (state_q != SHADOW) && !mem_br_taken && !reset;
      flush     = mem_br_taken && !reset;

      pc_hold     = stall_req;
      ifde_hold   = stall_req;
      idex_bubble = stall_req;
      flush_ifde  = flush;
      flush_idex  = flush;
      flush_exmem = flush;

      fwd_a = '0;
      fwd_b = '0;
      if (!reset) begin
         fwd_a = fwd_sel(ex_Rn, mem_RegWrite, mem_destreg, wb_RegWrite, wb_destreg);
         fwd_b = fwd_sel(ex_Rm, mem_RegWrite, mem_destreg, wb_RegWrite, wb_destreg);
      end
   end

   // STALL and RUN differ only in naming; SHADOW alone masks stall detection.
   always_comb begin
      state_d = RUN;
      if (mem_br_taken)
         state_d = SHADOW;
      else if (stall_req)
         state_d = STALL;
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_req && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
